// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five-button sync, debounce, one-shot pulse and single-pulse arbiter
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   btn_raw  raw active-high buttons {BTN7, BTN6, BTN5, BTN4, BTN0}
//   btn_out  conditioned pulses, same bit order, always zero or one-hot
//   busy     high while a pulse is active or lockout is running
module btn_conditioner #(
  parameter int DEB_CYCLES     = 20,
  parameter int PULSE_CYCLES   = 3,
  parameter int LOCKOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_out,
  output logic       busy
);

  localparam int NB = 5;
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [3:0]    PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);

  // ---------------- synchroniser ----------------
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= btn_raw;
      s_q     <= sync1_q;
    end
  end

  // ---------------- per-button debounce FSMs ----------------
  typedef enum logic [1:0] {B_IDLE, B_PRESS_WAIT, B_HELD, B_RELEASE_WAIT} bstate_e;

  bstate_e       bstate_q [NB];
  logic [CW-1:0] cnt_q    [NB];
  logic [CW-1:0] cnt_inc  [NB];
  logic [NB-1:0] qual;

  // The IDLE sample that starts PRESS_WAIT counts as the first stable
  // sample, so a press is accepted on its DEB_CYCLES-th consecutive high.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CW'(1);
      qual[i]    = 1'b0;
      if (DEB_CYCLES <= 1) begin
        qual[i] = (bstate_q[i] == B_IDLE) && s_q[i];
      end else begin
        qual[i] = (bstate_q[i] == B_PRESS_WAIT) && s_q[i] && (cnt_inc[i] == DEB_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        bstate_q[i] <= B_IDLE;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        case (bstate_q[i])
          B_IDLE: begin
            cnt_q[i] <= '0;
            if (s_q[i]) bstate_q[i] <= (DEB_CYCLES <= 1) ? B_HELD : B_PRESS_WAIT;
          end
          B_PRESS_WAIT: begin
            if (!s_q[i]) begin
              bstate_q[i] <= B_IDLE;
              cnt_q[i]    <= '0;
            end else if (qual[i]) begin
              bstate_q[i] <= B_HELD;
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          B_HELD: begin
            cnt_q[i] <= '0;
            if (!s_q[i]) bstate_q[i] <= (DEB_CYCLES <= 1) ? B_IDLE : B_RELEASE_WAIT;
          end
          B_RELEASE_WAIT: begin
            if (s_q[i]) begin
              bstate_q[i] <= B_HELD;
              cnt_q[i]    <= '0;
            end else if (cnt_inc[i] == DEB_LAST) begin
              bstate_q[i] <= B_IDLE;
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          default: begin
            bstate_q[i] <= B_IDLE;
            cnt_q[i]    <= '0;
          end
        endcase
      end
    end
  end

  // ---------------- arbiter / pulse generator ----------------
  typedef enum logic [1:0] {ARB_IDLE, ARB_PULSE, ARB_LOCK} astate_e;

  astate_e       astate_q;
  logic [NB-1:0] pending_q;
  logic [NB-1:0] pending_d;
  logic [NB-1:0] grant;
  logic [3:0]    pcnt_q;
  logic [LW-1:0] lcnt_q;
  logic [NB-1:0] btn_out_q;
  logic          busy_q;

  // Ascending scan: the highest pending index is the last to write, so BTN7 wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NB; i++) begin
      if (pending_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    // OR-ing qual in keeps a repeat press of an unserved button to a single event.
    pending_d = pending_q | qual;
    if (astate_q == ARB_IDLE) pending_d = (pending_q & ~grant) | qual;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate_q  <= ARB_IDLE;
      pending_q <= '0;
      pcnt_q    <= '0;
      lcnt_q    <= '0;
      btn_out_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (astate_q)
        ARB_IDLE: begin
          if (|pending_q) begin
            btn_out_q <= grant;
            busy_q    <= 1'b1;
            pcnt_q    <= '0;
            astate_q  <= ARB_PULSE;
          end
        end
        ARB_PULSE: begin
          if (pcnt_q == PULSE_LAST) begin
            btn_out_q <= '0;
            lcnt_q    <= '0;
            if (LOCKOUT_CYCLES == 0) begin
              busy_q   <= 1'b0;
              astate_q <= ARB_IDLE;
            end else begin
              astate_q <= ARB_LOCK;
            end
          end else begin
            pcnt_q <= pcnt_q + 4'd1;
          end
        end
        ARB_LOCK: begin
          if (lcnt_q == LOCK_LAST) begin
            busy_q   <= 1'b0;
            astate_q <= ARB_IDLE;
          end else begin
            lcnt_q <= lcnt_q + LW'(1);
          end
        end
        default: astate_q <= ARB_IDLE;
      endcase
    end
  end

  assign btn_out = btn_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed stimulus against a timeline model of debounce and arbitration
module tb_btn_conditioner;

  localparam int DEB = 20;
  localparam int P   = 3;
  localparam int L   = 50;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [4:0] btn_raw = 5'h1F;
  logic [4:0] btn_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  btn_conditioner #(
    .DEB_CYCLES(DEB),
    .PULSE_CYCLES(P),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_out(btn_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: sampled level delayed two edges, a run length of samples that
  // disagree with the accepted level, and a pulse timeline (start edge, next free edge).
  int         e;
  int         start;
  int         free_e;
  int         run [5];
  logic [4:0] pend;
  logic [4:0] lvl;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] gnt;
  logic [4:0] exp_out;
  logic       exp_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e        = 0;
      start    = -1000;
      free_e   = 0;
      pend     = '0;
      lvl      = '0;
      s1       = '0;
      s2       = '0;
      gnt      = '0;
      exp_out  = '0;
      exp_busy = 1'b0;
      for (int i = 0; i < 5; i++) run[i] = 0;
    end else begin
      e = e + 1;
      if (e >= free_e && pend != 5'b0) begin
        for (int i = 0; i < 5; i++) begin
          if (pend[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
          end
        end
        pend   = pend & ~gnt;
        start  = e;
        free_e = e + P + L + 1;
      end
      exp_out  = (e >= start && e < start + P) ? gnt : 5'b0;
      exp_busy = (e >= start && e < start + P + L);
      for (int i = 0; i < 5; i++) begin
        if (s2[i] != lvl[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == DEB) begin
            lvl[i] = s2[i];
            run[i] = 0;
            if (lvl[i]) pend[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      s2 = s1;
      s1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if (btn_out !== exp_out || busy !== exp_busy) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t btn_out=%b busy=%b expected btn_out=%b busy=%b",
               $time, btn_out, busy, exp_out, exp_busy);
    end
    checks = checks + 1;
    if (!$onehot0(btn_out)) begin
      errors = errors + 1;
      $display("FAIL onehot t=%0t btn_out=%b expected zero or one-hot", $time, btn_out);
    end
  end

  task automatic check(input string name, input int got, input int expv);
    checks = checks + 1;
    if (got !== expv) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // Counts rising clock edges until btn_out equals mask; -1 if budget runs out.
  task automatic wait_value(input logic [4:0] mask, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (btn_out == mask) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse_width(input logic [4:0] mask, output int n);
    n = 1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      if (btn_out != mask) break;
      n = n + 1;
    end
  endtask

  task automatic count_active(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (btn_out != 5'b0) n = n + 1;
    end
  endtask

  initial begin
    int n;
    int m;

    // reset with every button held
    repeat (3) @(negedge clk);
    check("reset_btn_out", int'(btn_out), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    wait_value(5'b10000, 100, n);
    check("held_at_reset_latency", n, 2 + DEB + 1);
    wait_value(5'b01000, 100, n);
    check("held_second_grant_gap", n, 54);
    btn_raw = 5'b0;
    repeat (300) @(negedge clk);
    check("drained_busy", int'(busy), 0);

    // clean press of BTN5
    btn_raw = 5'b00100;
    wait_value(5'b00100, 100, n);
    check("clean_latency", n, 23);
    pulse_width(5'b00100, n);
    check("clean_width", n, 3);
    count_active(70, n);
    check("clean_no_repeat", n, 0);
    btn_raw = 5'b0;
    repeat (100) @(negedge clk);

    // press bounce on BTN4, then settle high
    n = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw[1] = (k % 2 == 0);
      count_active(5, m);
      n = n + m;
    end
    check("bounce_quiet", n, 0);
    btn_raw[1] = 1'b1;
    wait_value(5'b00010, 100, n);
    check("bounce_settle_latency", n, 23);
    repeat (80) @(negedge clk);

    // release bounce: three glitches back high
    n = 0;
    for (int k = 0; k < 3; k++) begin
      btn_raw[1] = 1'b0;
      count_active(2, m);
      n = n + m;
      btn_raw[1] = 1'b1;
      count_active(2, m);
      n = n + m;
    end
    btn_raw[1] = 1'b0;
    count_active(100, m);
    n = n + m;
    check("release_bounce_no_pulse", n, 0);

    // simultaneous BTN7 and BTN0
    btn_raw = 5'b10001;
    wait_value(5'b10000, 100, n);
    check("simul_first_latency", n, 23);
    wait_value(5'b00001, 100, n);
    check("simul_second_gap", n, 54);
    btn_raw = 5'b0;
    repeat (100) @(negedge clk);

    // reset on the second cycle of a pulse
    btn_raw = 5'b01000;
    wait_value(5'b01000, 100, n);
    check("midreset_latency", n, 23);
    @(posedge clk);
    #2;
    check("midreset_pulse_active", int'(btn_out), 8);
    rst_n = 1'b0;
    #1;
    check("midreset_btn_out", int'(btn_out), 0);
    check("midreset_busy", int'(busy), 0);
    btn_raw = 5'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_active(60, n);
    check("midreset_no_resume", n, 0);

    // BTN6 qualifies during the lockout of a BTN7 pulse
    btn_raw = 5'b10000;
    repeat (13) @(posedge clk);
    @(negedge clk);
    btn_raw = 5'b11000;
    wait_value(5'b10000, 100, n);
    check("lockout_first_latency", n, 10);
    wait_value(5'b01000, 100, n);
    check("lockout_queued_gap", n, 54);
    btn_raw = 5'b0;
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
